// File: rtl/tdm_demux_1_to_8_pkg.sv
// ============================================================================
// Module  : tdm_pkg
// Brief   : Shared constants and state type for the 1-to-8 TDM demultiplexer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = $clog2(NUM_LANES);

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_t;

endpackage : tdm_pkg

`default_nettype wire

// File: rtl/tdm_demux_1_to_8_decoder.sv
// ============================================================================
// Module  : decoder_3_to_8
// Brief   : Combinational one-hot decode of a slot index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_3_to_8
    import tdm_pkg::*;
(
    input  logic [SEL_W-1:0]     sel,
    output logic [NUM_LANES-1:0] onehot
);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_dec
        assign onehot[k] = (sel == SEL_W'(k));
    end

endmodule : decoder_3_to_8

`default_nettype wire

// File: rtl/tdm_demux_1_to_8.sv
// ============================================================================
// Module  : tdm_demux_1_to_8
// Brief   : Serial-to-8-lane TDM demux with frame assembly and valid/ready
//           one-entry output holding register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux_1_to_8
    import tdm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_bit,
    input  logic                 in_valid,
    input  logic                 frame_sync,
    output logic [NUM_LANES-1:0] lane_strobe,
    output logic [SEL_W-1:0]     slot,
    output logic [NUM_LANES-1:0] word_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overflow,
    output logic                 sync_err
);

    tdm_state_t             r_state;
    tdm_state_t             w_state_next;
    logic [SEL_W-1:0]       r_slot;
    logic [NUM_LANES-1:0]   r_asm;
    logic [NUM_LANES-1:0]   r_word;
    logic                   r_word_valid;
    logic [NUM_LANES-1:0]   r_strobe;
    logic                   r_overflow;
    logic                   r_sync_err;

    logic                   w_accept;
    logic                   w_restart;
    logic                   w_sync_err_set;
    logic [SEL_W-1:0]       w_wr_slot;
    logic [NUM_LANES-1:0]   w_dec;
    logic [NUM_LANES-1:0]   w_asm_next;
    logic [NUM_LANES-1:0]   w_frame;
    logic                   w_complete;
    logic                   w_consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_restart marks a bit that starts a new frame at slot 0 (from HUNT or
    // a mid-frame resynchronisation that discards the partial frame).
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_restart      = 1'b0;
        w_sync_err_set = 1'b0;
        case (r_state)
            HUNT: begin
                if (in_valid && frame_sync) begin
                    w_accept     = 1'b1;
                    w_restart    = 1'b1;
                    w_state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (frame_sync && (r_slot != '0)) begin
                        w_restart      = 1'b1;
                        w_sync_err_set = 1'b1;
                    end
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    assign w_wr_slot = w_restart ? '0 : r_slot;

    decoder_3_to_8 u_decoder (
        .sel    (w_wr_slot),
        .onehot (w_dec)
    );

    assign w_asm_next = w_restart
                      ? {{(NUM_LANES-1){1'b0}}, in_bit}
                      : ((r_asm & ~w_dec) | ({NUM_LANES{in_bit}} & w_dec));
    assign w_frame    = {in_bit, r_asm[NUM_LANES-2:0]};
    assign w_complete = w_accept && (w_wr_slot == SEL_W'(NUM_LANES-1));
    assign w_consume  = r_word_valid && word_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot       <= '0;
            r_asm        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_strobe     <= '0;
            r_overflow   <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_strobe <= w_accept ? w_dec : '0;
            if (w_accept) begin
                r_slot <= w_wr_slot + SEL_W'(1);
                r_asm  <= w_asm_next;
            end
            if (w_sync_err_set) begin
                r_sync_err <= 1'b1;
            end
            // Holding register: a completed frame loads only when the slot is
            // free or being drained this cycle; otherwise it is dropped.
            if (w_complete && (!r_word_valid || word_ready)) begin
                r_word       <= w_frame;
                r_word_valid <= 1'b1;
            end else if (w_complete) begin
                r_overflow   <= 1'b1;
            end else if (w_consume) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign lane_strobe = r_strobe;
    assign slot        = r_slot;
    assign word_data   = r_word;
    assign word_valid  = r_word_valid;
    assign overflow    = r_overflow;
    assign sync_err    = r_sync_err;

endmodule : tdm_demux_1_to_8

`default_nettype wire

// File: tb/tb_tdm_demux_1_to_8.sv
// ============================================================================
// Module  : tb_tdm_demux_1_to_8
// Brief   : Self-checking bench for tdm_demux_1_to_8 (vector table, directed
//           corner sequences, randomized traffic against a frame-level model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_1_to_8;

    logic       clk;
    logic       reset;
    logic       in_bit;
    logic       in_valid;
    logic       frame_sync;
    logic [7:0] lane_strobe;
    logic [2:0] slot;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic       overflow;
    logic       sync_err;

    int n_cmp = 0;
    int n_bad = 0;

    tdm_demux_1_to_8 dut (
        .clk         (clk),
        .reset       (reset),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .frame_sync  (frame_sync),
        .lane_strobe (lane_strobe),
        .slot        (slot),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overflow    (overflow),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level reference model
    bit   m_hunt;
    int   m_slot;
    bit   m_bits [8];
    int   m_word;
    bit   m_wvalid;
    bit   m_ovf;
    bit   m_serr;
    int   m_strobe;

    function automatic void model_step(bit rst, bit v, bit b, bit fs, bit rdy);
        int  pos;
        bit  complete;
        int  frame_val;
        complete = 1'b0;
        if (rst) begin
            m_hunt = 1'b1; m_slot = 0; m_word = 0; m_wvalid = 1'b0;
            m_ovf = 1'b0; m_serr = 1'b0; m_strobe = 0;
            for (int k = 0; k < 8; k++) m_bits[k] = 1'b0;
            return;
        end
        m_strobe = 0;
        if (v && (!m_hunt || fs)) begin
            if (m_hunt) begin
                pos = 0;
                m_hunt = 1'b0;
            end else if (fs && m_slot != 0) begin
                pos = 0;
                m_serr = 1'b1;
            end else begin
                pos = m_slot;
            end
            m_bits[pos] = b;
            m_strobe = 1 << pos;
            m_slot = (pos + 1) % 8;
            complete = (pos == 7);
        end
        frame_val = 0;
        for (int k = 0; k < 8; k++) frame_val += int'(m_bits[k]) * (1 << k);
        if (complete) begin
            if (!m_wvalid || rdy) begin
                m_word = frame_val;
                m_wvalid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_wvalid && rdy) begin
            m_wvalid = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("lane_strobe", int'(lane_strobe), m_strobe);
        chk("slot",        int'(slot),        m_slot);
        chk("word_data",   int'(word_data),   m_word);
        chk("word_valid",  int'(word_valid),  int'(m_wvalid));
        chk("overflow",    int'(overflow),    int'(m_ovf));
        chk("sync_err",    int'(sync_err),    int'(m_serr));
    endtask

    // Drive one cycle, advance the model at the edge, compare 1 time unit later
    task automatic cycle(input bit rst, input bit v, input bit b, input bit fs, input bit rdy);
        reset = rst; in_valid = v; in_bit = b; frame_sync = fs; word_ready = rdy;
        @(posedge clk);
        model_step(rst, v, b, fs, rdy);
        #1;
        check_model();
    endtask

    task automatic send_frame(input logic [7:0] w, input bit sync_first, input bit rdy_last);
        for (int k = 0; k < 8; k++)
            cycle(1'b0, 1'b1, w[k], (k == 0) && sync_first, (k == 7) && rdy_last);
    endtask

    typedef struct packed {
        logic       rst, v, b, fs, rdy;
        logic [7:0] strobe;
        logic [2:0] slot;
        logic [7:0] data;
        logic       wv, ovf, serr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [7:0] pat;
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; frame_sync = 1'b0; word_ready = 1'b0;
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Scenario 1 as a vector table: bits 1,0,1,1,0,0,1,0 -> 8'h4D
        pat = 8'b0100_1101;
        tbl[0] = '{rst:1'b1, v:1'b0, b:1'b0, fs:1'b0, rdy:1'b0,
                   strobe:8'h00, slot:3'd0, data:8'h00, wv:1'b0, ovf:1'b0, serr:1'b0};
        for (int k = 0; k < 8; k++)
            tbl[k+1] = '{rst:1'b0, v:1'b1, b:pat[k], fs:(k == 0), rdy:1'b0,
                         strobe:8'(1 << k), slot:3'((k + 1) % 8),
                         data:(k == 7) ? 8'h4D : 8'h00, wv:(k == 7), ovf:1'b0, serr:1'b0};
        tbl[9] = '{rst:1'b0, v:1'b0, b:1'b0, fs:1'b0, rdy:1'b1,
                   strobe:8'h00, slot:3'd0, data:8'h4D, wv:1'b0, ovf:1'b0, serr:1'b0};
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].fs, tbl[i].rdy);
            chk($sformatf("tbl%0d_strobe", i), int'(lane_strobe), int'(tbl[i].strobe));
            chk($sformatf("tbl%0d_slot", i),   int'(slot),        int'(tbl[i].slot));
            chk($sformatf("tbl%0d_data", i),   int'(word_data),   int'(tbl[i].data));
            chk($sformatf("tbl%0d_valid", i),  int'(word_valid),  int'(tbl[i].wv));
            chk($sformatf("tbl%0d_ovf", i),    int'(overflow),    int'(tbl[i].ovf));
            chk($sformatf("tbl%0d_serr", i),   int'(sync_err),    int'(tbl[i].serr));
        end

        // Scenario 2: no frame_sync -> stays hunting
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, k[0], 1'b0, 1'b0);
        chk("hunt_slot", int'(slot), 0);
        chk("hunt_valid", int'(word_valid), 0);
        chk("hunt_strobe", int'(lane_strobe), 0);

        // Scenario 3: overflow while A is held
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("ovf_A_loaded", int'(word_data), 32'hA5);
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("ovf_data_held", int'(word_data), 32'hA5);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_valid_held", int'(word_valid), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_consumed", int'(word_valid), 0);

        // Scenario 4: consume and load in the same cycle
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("same_cyc_data", int'(word_data), 32'h3C);
        chk("same_cyc_valid", int'(word_valid), 1);
        chk("same_cyc_ovf", int'(overflow), 0);

        // Scenario 5: frame_sync at slot 4 mid-frame; new frame 8'h96
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1, k == 0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("resync_err", int'(sync_err), 1);
        chk("resync_slot", int'(slot), 1);
        chk("resync_strobe", int'(lane_strobe), 1);
        pat = 8'h96;
        for (int k = 1; k < 8; k++) cycle(1'b0, 1'b1, pat[k], 1'b0, 1'b0);
        chk("resync_word", int'(word_data), 32'h96);
        chk("resync_valid", int'(word_valid), 1);

        // Scenario 6: gaps hold slot, then reset at slot 5
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 1'b1, k == 0, 1'b0);
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("gap_slot", int'(slot), k + 1);
            chk("gap_strobe", int'(lane_strobe), 0);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_slot", int'(slot), 0);
        chk("rst_valid", int'(word_valid), 0);
        chk("rst_data", int'(word_data), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 7,
                  1'($urandom),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tdm_demux_1_to_8

`default_nettype wire
